// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store unit between the M stage and the data bus.
// Stalls the pipeline through an explicit handshake while the bus is busy,
// formats store data/byte enables, extracts and extends load data, and
// counts bus wait cycles.
module mem_stage_lsu #(
   parameter int N    = 64,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            reqvalid,
   input  logic            we,
   input  logic [1:0]      size,
   input  logic            signext,
   input  logic [N-1:0]    addr,
   input  logic [N-1:0]    wdata,
   output logic            stall,
   output logic            rvalid,
   output logic [N-1:0]    rdata,
   output logic            misalign,
   output logic            memreq,
   output logic            memwe,
   output logic [N-1:0]    memadr,
   output logic [N-1:0]    memwdata,
   output logic [N/8-1:0]  membe,
   input  logic            memabort,
   input  logic [N-1:0]    memrdata,
   output logic [CNTW-1:0] waitcnt
);

   localparam int NB = N / 8;
   localparam int LW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t         state, state_n;
   logic           aligned;
   logic           accept;
   logic           stall_i;
   logic           misalign_i;
   logic [LW-1:0]  lane;
   logic [LW-1:0]  lane_r;
   logic           we_r;
   logic           signext_r;
   logic [1:0]     size_r;
   logic [N-1:0]   wdata_fmt;
   logic [NB-1:0]  be_pat;
   logic [NB-1:0]  be_fmt;
   logic [N-1:0]   shifted;
   logic [N-1:0]   rdata_fmt;
   logic           ext;
   int unsigned    nb;

   assign lane = addr[LW-1:0];

   // Alignment: addr mod 2^size == 0; doubles never fit a 32-bit bus.
   always_comb begin
      aligned = 1'b1;
      case (size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~addr[0];
         2'd2:    aligned = (addr[1:0] == 2'b00);
         default: aligned = (N == 64) && (addr[2:0] == 3'b000);
      endcase
   end

   // Store data lane replication and byte enables (all lanes for loads).
   always_comb begin
      wdata_fmt = wdata;
      case (size)
         2'd0:    wdata_fmt = {NB{wdata[7:0]}};
         2'd1:    wdata_fmt = {(N/16){wdata[15:0]}};
         2'd2:    wdata_fmt = {(N/32){wdata[31:0]}};
         default: wdata_fmt = wdata;
      endcase
      be_pat = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         be_pat[i] = (i < (32'd1 << size));
      end
      be_fmt = we ? (be_pat << lane) : '1;
   end

   // Load extraction: shift the addressed lane down, keep 8*2^size bits, extend.
   always_comb begin
      shifted = memrdata >> {lane_r, 3'b000};
      nb      = 32'd8 << size_r;
      if (nb > unsigned'(N)) nb = unsigned'(N);
      ext = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (i + 1 == nb) ext = signext_r & shifted[i];
      end
      rdata_fmt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         rdata_fmt[i] = (i < nb) ? shifted[i] : ext;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_n    = state;
      accept     = 1'b0;
      stall_i    = 1'b0;
      misalign_i = 1'b0;
      rvalid     = 1'b0;
      memreq     = 1'b0;
      memwe      = 1'b0;
      case (state)
         IDLE: begin
            if (reqvalid && aligned) begin
               accept  = 1'b1;
               stall_i = 1'b1;
               state_n = BUSY;
            end else if (reqvalid) begin
               misalign_i = 1'b1;
            end
         end
         BUSY: begin
            stall_i = 1'b1;
            memreq  = 1'b1;
            memwe   = we_r;
            if (!memabort) state_n = RESP;
         end
         RESP: begin
            rvalid  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // While reset is held, IDLE would otherwise still reflect a pending reqvalid.
   assign stall    = stall_i & ~reset;
   assign misalign = misalign_i & ~reset;

   // Request capture, load result latch and wait-cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_r      <= 1'b0;
         size_r    <= 2'd0;
         signext_r <= 1'b0;
         lane_r    <= '0;
         memadr    <= '0;
         memwdata  <= '0;
         membe     <= '0;
         rdata     <= '0;
         waitcnt   <= '0;
      end else begin
         if (accept) begin
            we_r      <= we;
            size_r    <= size;
            signext_r <= signext;
            lane_r    <= lane;
            memadr    <= {addr[N-1:LW], {LW{1'b0}}};
            memwdata  <= wdata_fmt;
            membe     <= be_fmt;
         end
         if (state == BUSY && !memabort && !we_r) rdata <= rdata_fmt;
         if (state == BUSY && memabort && waitcnt != '1) waitcnt <= waitcnt + 1'b1;
      end
   end

endmodule
